// File: rtl/ps2_hex_receiver.sv
// PS/2 keyboard receiver: synchronises the raw bus, frames 11-bit packets,
// and decodes set-2 make/break codes of the hex keys into a held-key value.
module ps2_hex_receiver #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps_clk,
  input  logic       ps_dat,
  output logic [3:0] KeyboardBus,
  output logic       KeyPressed,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_clk_s1, r_clk_s2, r_clk_s3;
  logic            r_dat_s1, r_dat_s2;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [TW-1:0]   r_tocnt;
  logic            r_break, r_ext;
  logic            w_fall, w_timeout, w_accept, w_reject, w_par_ok;
  logic            w_hit;
  logic [3:0]      w_nib;

  assign w_fall   = r_clk_s3 & ~r_clk_s2;
  assign w_par_ok = ^{r_shift, r_par};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_timeout   = (r_state != IDLE) && !w_fall && (r_tocnt == TO_LAST);
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_reject    = 1'b1;
    end else if (w_fall) begin
      unique case (r_state)
        IDLE:   if (!r_dat_s2) w_state_nxt = DATA;
        DATA:   if (r_bitcnt == 3'd7) w_state_nxt = PARITY;
        PARITY: w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          if (r_dat_s2 && w_par_ok) w_accept = 1'b1;
          else                      w_reject = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_hit = 1'b1;
    w_nib = 4'h0;
    case (r_shift)
      8'h45: w_nib = 4'h0;
      8'h16: w_nib = 4'h1;
      8'h1E: w_nib = 4'h2;
      8'h26: w_nib = 4'h3;
      8'h25: w_nib = 4'h4;
      8'h2E: w_nib = 4'h5;
      8'h36: w_nib = 4'h6;
      8'h3D: w_nib = 4'h7;
      8'h3E: w_nib = 4'h8;
      8'h46: w_nib = 4'h9;
      8'h1C: w_nib = 4'hA;
      8'h32: w_nib = 4'hB;
      8'h21: w_nib = 4'hC;
      8'h23: w_nib = 4'hD;
      8'h24: w_nib = 4'hE;
      8'h2B: w_nib = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_clk_s3    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_tocnt     <= '0;
      r_break     <= 1'b0;
      r_ext       <= 1'b0;
      KeyboardBus <= '0;
      KeyPressed  <= 1'b0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_clk_s1   <= ps_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_s3   <= r_clk_s2;
      r_dat_s1   <= ps_dat;
      r_dat_s2   <= r_dat_s1;
      r_state    <= w_state_nxt;
      code_valid <= w_accept;
      frame_err  <= w_reject;

      if (w_fall || r_state == IDLE) r_tocnt <= '0;
      else                           r_tocnt <= r_tocnt + 1'b1;

      if (w_fall) begin
        case (r_state)
          IDLE: r_bitcnt <= '0;
          DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
          PARITY:  r_par <= r_dat_s2;
          default: ;
        endcase
      end

      // Decode acts on the completed byte in the stop-edge cycle so outputs land with code_valid.
      if (w_accept) begin
        if (r_shift == 8'hF0) begin
          r_break <= 1'b1;
        end else if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else begin
          r_break <= 1'b0;
          r_ext   <= 1'b0;
          if (w_hit && !r_ext) begin
            if (r_break) begin
              if (w_nib == KeyboardBus) KeyPressed <= 1'b0;
            end else begin
              KeyboardBus <= w_nib;
              KeyPressed  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_hex_receiver.sv
// Directed bench for ps2_hex_receiver: table of keyboard frames with expected
// decoder state, plus hand sequences for timeout and mid-frame reset.
module tb_ps2_hex_receiver;

  localparam int unsigned TO   = 100;
  localparam int          HALF = 8;
  localparam int          NV   = 21;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps_clk;
  logic       ps_dat;
  logic [3:0] KeyboardBus;
  logic       KeyPressed;
  logic       code_valid;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_hex_receiver #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps_clk     (ps_clk),
    .ps_dat     (ps_dat),
    .KeyboardBus(KeyboardBus),
    .KeyPressed (KeyPressed),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [7:0] data;
    bit         flip_par;
    bit         bad_stop;
    bit         exp_cv;
    logic [3:0] exp_bus;
    bit         exp_pr;
  } vec_t;

  vec_t vecs [NV];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         g_cv    = 0;
  int         g_fe    = 0;
  bit         g_both  = 1'b0;
  int         cv_at, fe_at, early, win;
  logic [3:0] bus_at;
  logic       pr_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (code_valid === 1'b1) g_cv++;
    if (frame_err === 1'b1) g_fe++;
    if (code_valid === 1'b1 && frame_err === 1'b1) g_both = 1'b1;
  endtask

  // Drives the first nbits of a frame; records pulses seen after the last falling edge.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits   = {~bad_stop, (~^d) ^ flip, d, 1'b0};
    cv_at  = 0;
    fe_at  = 0;
    early  = 0;
    win    = 0;
    bus_at = 'x;
    pr_at  = 'x;
    for (int i = 0; i < nbits; i++) begin
      ps_dat = bits[i];
      repeat (HALF) begin
        tick();
        if (code_valid === 1'b1 || frame_err === 1'b1) early++;
      end
      ps_clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        tick();
        if (i == nbits - 1) begin
          if (code_valid === 1'b1 && cv_at == 0) cv_at = k;
          if (frame_err === 1'b1 && fe_at == 0) fe_at = k;
          if (code_valid === 1'b1 || frame_err === 1'b1) win++;
          if (k == 3) begin
            bus_at = KeyboardBus;
            pr_at  = KeyPressed;
          end
        end else if (code_valid === 1'b1 || frame_err === 1'b1) begin
          early++;
        end
      end
      ps_clk = 1'b1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cv0, fe0, t, fe_first;

    vecs[0]  = '{8'h16, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1};
    vecs[1]  = '{8'h16, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1};
    vecs[3]  = '{8'h16, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
    vecs[4]  = '{8'h2B, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0};
    vecs[5]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1};
    vecs[6]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1};
    vecs[7]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1};
    vecs[8]  = '{8'h32, 1'b0, 1'b0, 1'b1, 4'hB, 1'b1};
    vecs[9]  = '{8'h21, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1};
    vecs[10] = '{8'hF0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1};
    vecs[11] = '{8'h32, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1};
    vecs[12] = '{8'h55, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1};
    vecs[13] = '{8'h45, 1'b0, 1'b1, 1'b0, 4'hC, 1'b1};
    vecs[14] = '{8'hF0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1};
    vecs[15] = '{8'h21, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0};
    vecs[16] = '{8'h2B, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1};
    vecs[17] = '{8'hE0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1};
    vecs[18] = '{8'hF0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1};
    vecs[19] = '{8'h2B, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1};
    vecs[20] = '{8'h16, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1};

    rst_n  = 1'b0;
    ps_clk = 1'b1;
    ps_dat = 1'b1;
    repeat (5) tick();
    check("reset bus", 32'(KeyboardBus), 32'h0);
    check("reset pressed", 32'(KeyPressed), 32'h0);
    check("reset code_valid", 32'(code_valid), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);

    rst_n = 1'b1;
    cv0 = g_cv;
    fe0 = g_fe;
    repeat (20) tick();
    check("release no code_valid", 32'(g_cv - cv0), 32'h0);
    check("release no frame_err", 32'(g_fe - fe0), 32'h0);

    for (int v = 0; v < NV; v++) begin
      send_frame(vecs[v].data, vecs[v].flip_par, vecs[v].bad_stop, 11);
      repeat (4) tick();
      check($sformatf("v%0d cv_cycle", v), 32'(cv_at), vecs[v].exp_cv ? 32'd3 : 32'd0);
      check($sformatf("v%0d fe_cycle", v), 32'(fe_at), vecs[v].exp_cv ? 32'd0 : 32'd3);
      check($sformatf("v%0d one_pulse", v), 32'(win), 32'd1);
      check($sformatf("v%0d early_pulse", v), 32'(early), 32'd0);
      check($sformatf("v%0d bus", v), 32'(bus_at), 32'(vecs[v].exp_bus));
      check($sformatf("v%0d pressed", v), 32'(pr_at), 32'(vecs[v].exp_pr));
    end

    // Start bit plus four data bits, then the bus goes quiet.
    send_frame(8'h45, 1'b0, 1'b0, 5);
    check("to partial early", 32'(early), 32'd0);
    check("to partial window", 32'(win), 32'd0);
    cv0      = g_cv;
    fe0      = g_fe;
    t        = HALF;
    fe_first = 0;
    while (t < int'(TO) + 40) begin
      tick();
      t++;
      if (frame_err === 1'b1 && fe_first == 0) fe_first = t;
    end
    check("to fe_cycle", 32'(fe_first), 32'(TO + 3));
    check("to fe_count", 32'(g_fe - fe0), 32'd1);
    check("to no code_valid", 32'(g_cv - cv0), 32'd0);
    check("to bus kept", 32'(KeyboardBus), 32'h1);
    send_frame(8'h45, 1'b0, 1'b0, 11);
    repeat (4) tick();
    check("after to cv_cycle", 32'(cv_at), 32'd3);
    check("after to bus", 32'(bus_at), 32'h0);
    check("after to pressed", 32'(pr_at), 32'h1);

    send_frame(8'h3E, 1'b0, 1'b0, 11);
    repeat (4) tick();
    check("pre-reset bus", 32'(bus_at), 32'h8);
    check("pre-reset pressed", 32'(pr_at), 32'h1);
    send_frame(8'h2E, 1'b0, 1'b0, 6);
    rst_n  = 1'b0;
    ps_clk = 1'b1;
    ps_dat = 1'b1;
    repeat (3) tick();
    check("midreset bus", 32'(KeyboardBus), 32'h0);
    check("midreset pressed", 32'(KeyPressed), 32'h0);
    check("midreset code_valid", 32'(code_valid), 32'h0);
    check("midreset frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    cv0 = g_cv;
    fe0 = g_fe;
    repeat (20) tick();
    check("post-reset quiet cv", 32'(g_cv - cv0), 32'd0);
    check("post-reset quiet fe", 32'(g_fe - fe0), 32'd0);
    send_frame(8'h3D, 1'b0, 1'b0, 11);
    repeat (4) tick();
    check("post-reset cv_cycle", 32'(cv_at), 32'd3);
    check("post-reset early", 32'(early), 32'd0);
    check("post-reset bus", 32'(bus_at), 32'h7);
    check("post-reset pressed", 32'(pr_at), 32'h1);

    check("cv_fe_exclusive", 32'(g_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
